axichannel_valid_recorder: RTL and testbench

- Inline recorder for one AXI channel, placed between the recorded master (upstream) and the slave (downstream).
- Emits one trace record for each cycle in which a transaction begins (logb: valid first presented, with payload) or ends (loge: valid&&ready handshake).
- Records are buffered in an internal FIFO toward the packing/merge tree.
- A new transaction is only admitted downstream when the buffer can absorb its complete record pair, so no record is ever dropped. This is the record-side counterpart of the valid replayer, producing the logb/loge stream it consumes.

---
 rtl/axichannel_valid_recorder.sv | 133 +++++++++++++
 tb/tb_axichannel_valid_recorder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/axichannel_valid_recorder.sv
// Inline recorder for one AXI valid/ready channel.
// Emits logb/loge trace records into a first-word-fall-through FIFO.
module axichannel_valid_recorder #(
    parameter int DATA_WIDTH   = 64,
    parameter int FIFO_DEPTH   = 32,
    parameter int ALMFUL_SLACK = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  up_valid,
    output logic                  up_ready,
    input  logic [DATA_WIDTH-1:0] up_data,
    output logic                  dn_valid,
    input  logic                  dn_ready,
    output logic [DATA_WIDTH-1:0] dn_data,
    output logic                  rec_valid,
    input  logic                  rec_ready,
    output logic                  rec_logb_valid,
    output logic [DATA_WIDTH-1:0] rec_logb_data,
    output logic                  rec_loge_valid,
    output logic [CNT_WIDTH-1:0]  logb_cnt,
    output logic [CNT_WIDTH-1:0]  loge_cnt,
    output logic                  fifo_overflow,
    output logic                  fifo_underflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_WIDTH + 2;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] NEED    = (AW+1)'(2 + ALMFUL_SLACK);

    typedef enum logic {IDLE, PENDING} state_t;

    state_t        state;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_count;
    logic [AW:0]   free_cnt;
    logic          can_start;
    logic          full;
    logic          wr_en;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;
    logic          push;
    logic          pop;

    assign free_cnt  = DEPTH_C - fifo_count;
    assign can_start = free_cnt >= NEED;
    assign full      = fifo_count == DEPTH_C;

    // Admission: a new transaction passes only if its whole record pair fits.
    always_comb begin
        dn_valid = 1'b0;
        if (!rst) begin
            if (state == IDLE) dn_valid = up_valid && can_start;
            else               dn_valid = up_valid;
        end
    end

    assign up_ready = dn_valid && dn_ready;
    assign dn_data  = up_data;

    // Record generation: logb on admission, loge on a later handshake.
    always_comb begin
        wr_en    = 1'b0;
        wr_entry = '0;
        if (state == IDLE && dn_valid) begin
            wr_en    = 1'b1;
            wr_entry = {1'b1, up_data, dn_ready};
        end else if (state == PENDING && dn_valid && dn_ready) begin
            wr_en    = 1'b1;
            wr_entry = {1'b0, {DATA_WIDTH{1'b0}}, 1'b1};
        end
    end

    assign push      = wr_en && !full;
    assign rec_valid = fifo_count != '0;
    assign pop       = rec_valid && rec_ready;
    assign rd_entry  = mem[rd_ptr];

    assign rec_logb_valid = rec_valid && rd_entry[EW-1];
    assign rec_logb_data  = rec_logb_valid ?
                            rd_entry[EW-2:1] : '0;
    assign rec_loge_valid = rec_valid && rd_entry[0];

    // Transaction FSM: PENDING holds between admission and handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE:    if (dn_valid && !dn_ready) state <= PENDING;
                PENDING: if (dn_valid && dn_ready)  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Record storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      fifo_count <= fifo_count + (AW+1)'(1);
            else if (!push && pop) fifo_count <= fifo_count - (AW+1)'(1);
        end
    end

    // Event counters and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            logb_cnt       <= '0;
            loge_cnt       <= '0;
            fifo_overflow  <= 1'b0;
            fifo_underflow <= 1'b0;
        end else begin
            if (wr_en && wr_entry[EW-1]) logb_cnt <= logb_cnt + CNT_WIDTH'(1);
            if (wr_en && wr_entry[0])    loge_cnt <= loge_cnt + CNT_WIDTH'(1);
            if (wr_en && full)           fifo_overflow  <= 1'b1;
            if (pop && fifo_count == '0) fifo_underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axichannel_valid_recorder.sv
// Scoreboard bench for axichannel_valid_recorder.
// Stimulus queues expected records; a negedge monitor checks pops.
module tb_axichannel_valid_recorder;
    localparam int DW = 16;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          up_valid;
    logic          up_ready;
    logic [DW-1:0] up_data;
    logic          dn_valid;
    logic          dn_ready;
    logic [DW-1:0] dn_data;
    logic          rec_valid;
    logic          rec_ready;
    logic          rec_logb_valid;
    logic [DW-1:0] rec_logb_data;
    logic          rec_loge_valid;
    logic [CW-1:0] logb_cnt;
    logic [CW-1:0] loge_cnt;
    logic          fifo_overflow;
    logic          fifo_underflow;

    int checks;
    int failures;
    logic [DW+1:0] exp_q[$];

    axichannel_valid_recorder #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(8),
        .ALMFUL_SLACK(2),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .up_valid(up_valid),
        .up_ready(up_ready),
        .up_data(up_data),
        .dn_valid(dn_valid),
        .dn_ready(dn_ready),
        .dn_data(dn_data),
        .rec_valid(rec_valid),
        .rec_ready(rec_ready),
        .rec_logb_valid(rec_logb_valid),
        .rec_logb_data(rec_logb_data),
        .rec_loge_valid(rec_loge_valid),
        .logb_cnt(logb_cnt),
        .loge_cnt(loge_cnt),
        .fifo_overflow(fifo_overflow),
        .fifo_underflow(fifo_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every popped record must match the scoreboard head.
    always @(negedge clk) begin
        logic [DW+1:0] got;
        logic [DW+1:0] exp;
        if (!rst && rec_valid && rec_ready) begin
            got = {rec_logb_valid, rec_logb_data, rec_loge_valid};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rec_unexpected got=%h", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    failures++;
                    $display("FAIL rec_payload got=%h expected=%h", got, exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction; dly = cycles from valid to dn_ready.
    task automatic txn(input logic [DW-1:0] d, input int dly, input bit imm);
        int n;
        up_valid = 1'b1;
        up_data  = d;
        dn_ready = (dly == 0);
        n = 0;
        #1;
        while (!dn_valid && n < 100) begin
            step();
            n++;
        end
        check("admit", {31'd0, dn_valid}, 32'd1);
        if (imm) check("admit_wait", n, 32'd0);
        check("dn_data", {16'd0, dn_data}, {16'd0, d});
        if (dly == 0) check("up_ready_same", {31'd0, up_ready}, 32'd1);
        else          check("up_ready_hold", {31'd0, up_ready}, 32'd0);
        exp_q.push_back({1'b1, d, dly == 0});
        step();
        if (dly > 0) begin
            repeat (dly - 1) step();
            dn_ready = 1'b1;
            #1;
            check("up_ready_late", {31'd0, up_ready}, 32'd1);
            exp_q.push_back({1'b0, {DW{1'b0}}, 1'b1});
            step();
        end
        up_valid = 1'b0;
        dn_ready = 1'b0;
    endtask

    task automatic drain();
        int n;
        rec_ready = 1'b1;
        n = 0;
        while (rec_valid && n < 100) begin
            step();
            n++;
        end
        check("drain_q", exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        up_valid  = 1'b1;
        up_data   = 16'h0;
        dn_ready  = 1'b1;
        rec_ready = 1'b1;
        #1;
        check("rst_dn_valid", {31'd0, dn_valid}, 32'd0);
        check("rst_up_ready", {31'd0, up_ready}, 32'd0);
        check("rst_rec_valid", {31'd0, rec_valid}, 32'd0);
        check("rst_logb_cnt", {28'd0, logb_cnt}, 32'd0);
        check("rst_flags", {30'd0, fifo_overflow, fifo_underflow}, 32'd0);
        up_valid = 1'b0;
        dn_ready = 1'b0;
        #10 rst = 1'b0;
        step();

        // Same-cycle handshake.
        txn(16'h00A5, 0, 1'b1);
        check("t1_rec_valid", {31'd0, rec_valid}, 32'd1);
        check("t1_logb_cnt", {28'd0, logb_cnt}, 32'd1);
        check("t1_loge_cnt", {28'd0, loge_cnt}, 32'd1);
        step();

        // Delayed handshake, then immediate re-admission.
        txn(16'h0011, 3, 1'b1);
        check("t2_logb_cnt", {28'd0, logb_cnt}, 32'd2);
        check("t2_loge_cnt", {28'd0, loge_cnt}, 32'd2);
        drain();

        // Back-to-back single-cycle transactions.
        for (int i = 0; i < 4; i++) txn(16'h0100 + 16'(i), 0, 1'b1);
        check("b2b_logb_cnt", {28'd0, logb_cnt}, 32'd6);
        drain();

        // Backpressure: five records fit, sixth must wait for a pop.
        rec_ready = 1'b0;
        for (int i = 0; i < 5; i++) txn(16'h0200 + 16'(i), 0, 1'b1);
        up_valid = 1'b1;
        up_data  = 16'h0066;
        dn_ready = 1'b1;
        #1;
        check("bp_block_dn", {31'd0, dn_valid}, 32'd0);
        check("bp_block_up", {31'd0, up_ready}, 32'd0);
        step();
        check("bp_still", {31'd0, dn_valid}, 32'd0);
        rec_ready = 1'b1;
        step();
        rec_ready = 1'b0;
        #1;
        check("bp_admit_dn", {31'd0, dn_valid}, 32'd1);
        check("bp_admit_up", {31'd0, up_ready}, 32'd1);
        exp_q.push_back({1'b1, 16'h0066, 1'b1});
        step();
        up_valid = 1'b0;
        dn_ready = 1'b0;
        check("bp_overflow", {31'd0, fifo_overflow}, 32'd0);
        drain();

        // Reset in the middle of a pending transaction.
        rec_ready = 1'b0;
        up_valid  = 1'b1;
        up_data   = 16'h0033;
        dn_ready  = 1'b0;
        #1;
        check("mp_dn_valid", {31'd0, dn_valid}, 32'd1);
        exp_q.push_back({1'b1, 16'h0033, 1'b0});
        step();
        step();
        check("mp_rec_before", {31'd0, rec_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mp_dn_async", {31'd0, dn_valid}, 32'd0);
        check("mp_rec_async", {31'd0, rec_valid}, 32'd0);
        exp_q.delete();
        up_valid = 1'b0;
        #3 rst = 1'b0;
        step();
        check("mp_logb_cnt", {28'd0, logb_cnt}, 32'd0);
        check("mp_loge_cnt", {28'd0, loge_cnt}, 32'd0);
        rec_ready = 1'b1;
        txn(16'h0044, 0, 1'b1);
        check("mp_after_cnt", {28'd0, logb_cnt}, 32'd1);
        drain();

        // Counter wrap at 4 bits.
        rst = 1'b1;
        #2 rst = 1'b0;
        step();
        for (int i = 0; i < 17; i++) txn(16'h0300 + 16'(i), 0, 1'b1);
        check("wrap_logb_cnt", {28'd0, logb_cnt}, 32'd1);
        check("wrap_loge_cnt", {28'd0, loge_cnt}, 32'd1);
        drain();
        check("end_flags", {30'd0, fifo_overflow, fifo_underflow}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
